serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Bit-serial N-bit adder/subtractor: loads two WIDTH-bit operands and a mode bit, then processes one bit per clock, LSB first.
- Per-bit datapath is a 1-bit full adder/subtractor slice with a registered carry between bits.
- Sits upstream of result consumers. Used where area matters more than latency.
- Start/busy/done handshake towards the controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- mode_in  input  1  0 = A+B, 1 = A-B; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  sum/difference; held until next accepted start
- cout  output  1  final carry; for subtraction, 1 = no borrow (A >= B unsigned)
- ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, result, cout and ovf all go to 0.
  - Operand shift registers, bit counter and carry flop clear to 0.
  - Reset has effect at any time, including mid-operation; the operation is abandoned and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures a_in, b_in and mode_in.
  - Carry flop loads mode_in.
  - Bit counter loads 0.
  - Next state is RUN.
- RUN:
  - At edges E1..E(WIDTH), bit i = counter value is processed.
  - b' = b_i XOR mode.
  - s = a_i XOR b' XOR c.
  - c_next = (a_i AND b') OR (c AND (a_i XOR b')).
  - s shifts into result from the MSB side, so after WIDTH shifts result[0] holds bit 0.
  - Operand registers shift right; the carry flop takes c_next.
  - On the edge processing bit WIDTH-1, the next state is DONE and cout is set to c_next.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next state is IDLE, or RUN if start=1 in this cycle. A back-to-back start reloads operands at that edge; done still deasserts.
- busy = 1 exactly in RUN; done = 1 exactly in DONE. Both are registered outputs.
- Latency: done is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after the start edge counting E0. Throughput is one operation per WIDTH+1 cycles.
- start=1 while in RUN is ignored. No queuing, and operands are not disturbed.
- a_in, b_in and mode_in are don't-care except at the accepting edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- result and cout are only updated by a completing operation. They keep their last value through IDLE until the next completion. The result shift register may change during RUN; consumers must sample on done.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - ovf is registered at the last-bit edge as the carry into the MSB XOR the carry out of the MSB.
  - This is two's-complement overflow for both add and subtract.
  - ovf is valid with done and held like result.
  - It is cleared by reset.
- Not defined: ovf is tied to constant 0 and the MSB carry-in tracking logic is not built.

Test Plan (WIDTH=8):
1. Add: rst pulse, then start with a=100, b=27, mode=0 -> busy high for 8 cycles, done pulse 9 edges after the start edge, result=127, cout=0.
2. Add wrap: a=0xFF, b=0x01, mode=0 -> result=0x00, cout=1; ovf=0 with macro defined.
3. Subtract: a=50, b=20, mode=1 -> result=30, cout=1. Then a=20, b=50, mode=1 -> result=0xE2, cout=0.
4. Handshake: in RUN, assert start with a=1, b=1 -> ignored, result still 127 for a=100, b=27. Start asserted during the DONE cycle with a=3, b=4 -> accepted, next done gives 7.
5. Reset mid-op: start a=100, b=27, assert rst after 4 RUN cycles -> busy=0, done=0, result=0, cout=0 immediately (asynchronous, no clock edge needed), state IDLE, and no done pulse afterwards.
6. Overflow, macro defined: a=0x7F, b=0x01, mode=0 -> result=0x80, ovf=1. Then a=0x80, b=0x01, mode=1 -> result=0x7F, ovf=1. Macro undefined: same stimulus -> ovf=0.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: controller <-> bit-serial adder/subtractor handshake bundle.
// master = controller issuing operations, slave = the serial_add_sub datapath.
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             mode_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a_in, b_in, mode_in,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, a_in, b_in, mode_in,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// A 1-bit full adder slice with a registered carry walks the operands; the sum
// bits shift into the result register from the MSB side.
// Optional feature: define SERIAL_ADD_SUB_OVF_EN to build the signed overflow
// flag; without it ovf is tied to 0 and no MSB carry-in tracking exists.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   serial_add_sub_if.slave bus
);

   localparam int cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [cnt_w-1:0] last_bit = cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      st_idle,
      st_run,
      st_done
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [cnt_w-1:0] cnt_q;
   logic             mode_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   logic             accept;
   logic             last;
   logic             b_eff;
   logic             sum_bit;
   logic             carry_next;

   // Start is honoured only outside RUN, so an active operation is never disturbed.
   assign accept = bus.start && (state_q != st_run);
   assign last   = (state_q == st_run) && (cnt_q == last_bit);

   // One full adder/subtractor slice; subtraction is A + ~B + 1 with the +1
   // coming from the carry flop preloaded with the mode bit.
   assign b_eff      = b_q[0] ^ mode_q;
   assign sum_bit    = a_q[0] ^ b_eff ^ carry_q;
   assign carry_next = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));

   // Next-state decode for the IDLE/RUN/DONE sequencer.
   always_comb begin
      // NOTE: default assigned first so every path drives state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         st_idle: if (bus.start) state_d = st_run;
         st_run:  if (last) state_d = st_done;
         st_done: state_d = bus.start ? st_run : st_idle;
         default: state_d = st_idle;
      endcase
   end

   // State register plus registered busy/done derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= st_idle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments in clocked blocks so all flops update together at the edge.
         state_q <= state_d;
         busy_q  <= (state_d == st_run);
         done_q  <= (state_d == st_done);
      end
   end

   // Operand capture on accepted start, then one shift/carry step per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a_in;
         b_q     <= bus.b_in;
         mode_q  <= bus.mode_in;
         carry_q <= bus.mode_in;
         cnt_q   <= '0;
      end else if (state_q == st_run) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         carry_q <= carry_next;
         cnt_q   <= cnt_q + cnt_w'(1);
         res_q   <= {sum_bit, res_q[WIDTH-1:1]};
         if (last) cout_q <= carry_next;
      end
   end

`ifdef SERIAL_ADD_SUB_OVF_EN
   logic ovf_q;

   // At the last bit carry_q is the carry into the MSB; differing from the
   // carry out of the MSB means two's-complement overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last) begin
         ovf_q <= carry_q ^ carry_next;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub (WIDTH=8).
// Expected results come from plain integer arithmetic; a monitor pops and
// compares them whenever done is seen.
module tb_serial_add_sub;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] result;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t sb[$];

   serial_add_sub_if #(.WIDTH(W)) bus ();

   serial_add_sub #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: modular unsigned arithmetic for result/cout, signed range test for ovf.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t   e;
      longint ua, ub, sa, sbv, full, sres;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (!m) begin
         full   = ua + ub;
         e.cout = (full >= (longint'(1) << W));
         sres   = sa + sbv;
      end else begin
         full   = ua - ub;
         e.cout = (ua >= ub);
         sres   = sa - sbv;
      end
      e.result = full[W-1:0];
`ifdef SERIAL_ADD_SUB_OVF_EN
      e.ovf = (sres > ((longint'(1) << (W - 1)) - 1)) || (sres < -(longint'(1) << (W - 1)));
`else
      e.ovf = 1'b0;
`endif
      return e;
   endfunction

   // Caller sits at a negedge; start is accepted at the following posedge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      bus.start   = 1'b1;
      bus.a_in    = a;
      bus.b_in    = b;
      bus.mode_in = m;
      sb.push_back(model(a, b, m));
   endtask

   // Returns at the negedge where done is seen; lat counts negedges since start_op.
   task automatic wait_done(output int lat, output int busy_cnt);
      bit seen;
      lat      = 0;
      busy_cnt = 0;
      seen     = 1'b0;
      while (!seen && lat < 4 * W) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.start   = 1'b0;
            bus.a_in    = W'($urandom);
            bus.b_in    = W'($urandom);
            bus.mode_in = 1'($urandom);
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", 4 * W);
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      int lat, bc;
      start_op(a, b, m);
      wait_done(lat, bc);
      @(negedge clk);
   endtask

   // Monitor: every done must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done with nothing pending, result=%0h", bus.result);
         end else begin
            e = sb.pop_front();
            check("result", 32'(bus.result), 32'(e.result));
            check("cout", 32'(bus.cout), 32'(e.cout));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      int lat, bc, gap;
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.a_in    = '0;
      bus.b_in    = '0;
      bus.mode_in = 1'b0;

      // Reset state
      #12;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_result", 32'(bus.result), 0);
      check("rst_cout", 32'(bus.cout), 0);
      check("rst_ovf", 32'(bus.ovf), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1. Add with latency, busy length, one-cycle done and hold checks
      start_op(8'd100, 8'd27, 1'b0);
      wait_done(lat, bc);
      check("latency", 32'(lat), 32'(W + 1));
      check("busy_cycles", 32'(bc), 32'(W));
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 0);
      repeat (3) @(negedge clk);
      check("result_held", 32'(bus.result), 127);
      check("cout_held", 32'(bus.cout), 0);
      check("idle_busy", 32'(bus.busy), 0);

      // 2/3/6. Directed boundary operations
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'd50, 8'd20, 1'b1);
      do_op(8'd20, 8'd50, 1'b1);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'h80, 8'h01, 1'b1);
      do_op(8'h00, 8'h00, 1'b1);
      do_op(8'h80, 8'h80, 1'b0);

      // 4. Start during RUN is ignored; start during DONE chains
      start_op(8'd100, 8'd27, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = 8'd1;
      bus.b_in  = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, bc);
      start_op(8'd3, 8'd4, 1'b0);
      wait_done(lat, bc);
      check("chain_latency", 32'(lat), 32'(W + 1));
      check("chain_result", 32'(bus.result), 7);
      @(negedge clk);

      // 5. Reset mid-operation: immediate clear, no done afterwards
      start_op(8'd100, 8'd27, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_done", 32'(bus.done), 0);
      check("midrst_result", 32'(bus.result), 0);
      check("midrst_cout", 32'(bus.cout), 0);
      check("midrst_ovf", 32'(bus.ovf), 0);
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bc  = 0;
      repeat (3 * W) begin
         @(negedge clk);
         if (bus.busy) bc++;
      end
      check("post_rst_idle", 32'(bc), 0);

      // Randomised operations, with random back-to-back chaining
      for (int i = 0; i < 40; i++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         wait_done(lat, bc);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
